mem_access_unit: RTL

Memory-stage data-bus master sitting between the EX_MEM register and the MEM_WB register. It turns a load/store from EX_MEM into a single request/acknowledge transaction on the data-memory bus and freezes the upstream pipeline while the access is outstanding. It returns the byte/half/word-formatted load result to MEM_WB. A timeout counter bounds every access so a silent slave cannot hang the core.

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage master and the data-memory slave.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus master: one req/ack transaction per load/store,
// pipeline stall while outstanding, formatted load result, bounded by a
// timeout counter.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// trapped (no bus request, one-cycle misalign_out) instead of force-aligned.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic [2:0]                funct3_in,
  input  logic [31:0]               mem_addr_in,
  input  logic [31:0]               store_data_in,
  mem_access_unit_if.master         dmem,
  output logic                      stall_out,
  output logic [31:0]               load_data_out,
  output logic                      done_out,
  output logic                      bus_err_out,
  output logic                      misalign_out
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state, w_next;
  logic            r_req, r_we, r_err;
  logic [31:0]     r_addr, r_wdata, r_load;
  logic [3:0]      r_wstrb;
  logic [2:0]      r_f3;
  logic [1:0]      r_lo;
  logic [CW-1:0]   r_cnt;

  logic            w_legal, w_access, w_trap, w_mem_op, w_expire;
  logic            w_stall, w_done, w_mis;
  logic [3:0]      w_wstrb;
  logic [31:0]     w_wdata, w_fmt;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // Decode: legal width codes and whether this slot needs the bus
  always_comb begin
    w_legal  = (funct3_in == 3'b000) || (funct3_in == 3'b001) ||
               (funct3_in == 3'b010) || (funct3_in == 3'b100) ||
               (funct3_in == 3'b101);
    w_access = valid_in & (mem_read_in | mem_write_in) & w_legal;
`ifdef MEM_MISALIGN_TRAP_EN
    w_trap   = w_access &
               (((funct3_in[1:0] == 2'b01) & mem_addr_in[0]) |
                ((funct3_in[1:0] == 2'b10) & (|mem_addr_in[1:0])));
`else
    w_trap   = 1'b0;
`endif
    w_mem_op = w_access & ~w_trap;
  end

  // Store lane steering; reads drive no byte enables
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'd0;
    if (mem_write_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << mem_addr_in[1:0];
          w_wdata = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          w_wstrb = mem_addr_in[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data_in[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = store_data_in;
        end
      endcase
    end
  end

  // Load formatting from the captured address lane and width code
  always_comb begin
    case (r_lo)
      2'd0:    w_byte = dmem.dmem_rdata[7:0];
      2'd1:    w_byte = dmem.dmem_rdata[15:8];
      2'd2:    w_byte = dmem.dmem_rdata[23:16];
      default: w_byte = dmem.dmem_rdata[31:24];
    endcase
    w_half = r_lo[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (r_f3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {24'd0, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_fmt = {16'd0, w_half};
      default: w_fmt = dmem.dmem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state and stage control
  always_comb begin
    w_next   = r_state;
    w_stall  = 1'b0;
    w_done   = 1'b0;
    w_mis    = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      IDLE: begin
        w_mis  = w_trap;
        w_done = w_trap;
        if (w_mem_op) begin
          w_stall = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (dmem.dmem_ack) begin
          w_next = DONE;
        end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1))) begin
          w_expire = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus registers, timeout counter and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_f3    <= 3'd0;
      r_lo    <= 2'd0;
      r_cnt   <= '0;
      r_load  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_err <= 1'b0;
          if (w_mem_op) begin
            r_req   <= 1'b1;
            r_we    <= mem_write_in;
            r_addr  <= {mem_addr_in[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_f3    <= funct3_in;
            r_lo    <= mem_addr_in[1:0];
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            r_req  <= 1'b0;
            r_load <= r_we ? 32'd0 : w_fmt;
            r_err  <= 1'b0;
          end else if (w_expire) begin
            r_req  <= 1'b0;
            r_load <= 32'd0;
            r_err  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign dmem.dmem_wstrb = r_wstrb;

  assign stall_out     = w_stall & ~rst;
  assign done_out      = w_done & ~rst;
  assign misalign_out  = w_mis & ~rst;
  assign bus_err_out   = r_err;
  assign load_data_out = (r_state == DONE) ? r_load : 32'd0;

endmodule
